// File: rtl/i2c_req_arbiter_pkg.sv
// rtl/i2c_req_arbiter_pkg.sv - shared encodings, defaults and helpers for the i2c request arbiter
package i2c_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_XFER   = 2'd2,
        ST_FIN    = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_LEN = 7;
    localparam int DEF_DATA_LEN = 8;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// rtl/i2c_req_arbiter_rr_pick.sv - combinational round-robin winner select
module i2c_req_arbiter_rr_pick
    import i2c_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan upward from rr_ptr with wrap; the first set request bit wins
    always_comb begin : pick
        int p;
        p     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            p = (int'(rr_ptr) + k) % NUM_REQ;
            if (!valid && req[p]) begin
                valid  = 1'b1;
                idx    = IDX_W'(p);
                gnt[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin sharing of one fsm_master among several requesters
module i2c_req_arbiter
    import i2c_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_LEN  = DEF_ADDR_LEN,
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int LAUNCH_TO = 16,
    parameter int XFER_TO   = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data1,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data2,
    input  logic [NUM_REQ-1:0]           req_ack3p,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic                         m_start,
    output logic [ADDR_LEN-1:0]          m_addr,
    output logic                         m_rw,
    output logic [DATA_LEN-1:0]          m_data1,
    output logic [DATA_LEN-1:0]          m_data2,
    output logic                         m_ack3p,
    input  logic                         m_free
);

    localparam int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int TMR_MAX = (LAUNCH_TO > XFER_TO) ? LAUNCH_TO : XFER_TO;
    localparam int TMR_W   = (TMR_MAX > 1) ? clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] LAUNCH_LAST = TMR_W'(LAUNCH_TO - 1);
    localparam logic [TMR_W-1:0] XFER_LAST   = TMR_W'(XFER_TO - 1);
    localparam logic [TMR_W-1:0] TMR_FULL    = '1;

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [TMR_W-1:0]   tmr;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [TMR_W-1:0]   tmr_inc;
    logic [IDX_W-1:0]   next_ptr;

    i2c_req_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Saturating timer step and the pointer just past the current owner
    always_comb begin
        tmr_inc  = (tmr == TMR_FULL) ? tmr : tmr + 1'b1;
        next_ptr = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
    end

    // Arbiter FSM: grant, hold start until the master goes busy, wait for idle, pulse result
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            m_start <= 1'b0;
            m_addr  <= '0;
            m_rw    <= 1'b0;
            m_data1 <= '0;
            m_data2 <= '0;
            m_ack3p <= 1'b0;
            rr_ptr  <= '0;
            owner   <= '0;
            tmr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid && m_free) begin
                        gnt     <= pick_gnt;
                        owner   <= pick_idx;
                        m_addr  <= req_addr[pick_idx*ADDR_LEN +: ADDR_LEN];
                        m_rw    <= req_rw[pick_idx];
                        m_data1 <= req_data1[pick_idx*DATA_LEN +: DATA_LEN];
                        m_data2 <= req_data2[pick_idx*DATA_LEN +: DATA_LEN];
                        m_ack3p <= req_ack3p[pick_idx];
                        tmr     <= '0;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // tmr counts only cycles in which start is actually presented
                    if (!m_start) begin
                        m_start <= 1'b1;
                    end else if (!m_free) begin
                        m_start <= 1'b0;
                        tmr     <= '0;
                        state   <= ST_XFER;
                    end else if (tmr == LAUNCH_LAST) begin
                        m_start <= 1'b0;
                        err     <= gnt;
                        state   <= ST_FIN;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                ST_XFER: begin
                    if (m_free) begin
                        done  <= gnt;
                        state <= ST_FIN;
                    end else if (tmr == XFER_LAST) begin
                        err   <= gnt;
                        state <= ST_FIN;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                ST_FIN: begin
                    done   <= '0;
                    err    <= '0;
                    gnt    <= '0;
                    rr_ptr <= next_ptr;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - directed self-checking bench for i2c_req_arbiter
module tb_i2c_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_data1;
    logic [31:0] req_data2;
    logic [3:0]  req_ack3p;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        m_start;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_data1;
    logic [7:0]  m_data2;
    logic        m_ack3p;
    logic        m_free;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_req_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_ack3p (req_ack3p),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_data1   (m_data1),
        .m_data2   (m_data2),
        .m_ack3p   (m_ack3p),
        .m_free    (m_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       ack;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester i: addr 4F+i, rw 1100, data1 A4+i, data2 i*16+3, ack3p 1010
    task automatic set_fields();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*7 +: 7]  = 7'(7'h4F + i);
            req_data1[i*8 +: 8] = 8'(8'hA4 + i);
            req_data2[i*8 +: 8] = 8'(i * 16 + 3);
        end
        req_rw    = 4'b1100;
        req_ack3p = 4'b1010;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outs", {gnt, done, err, 3'b0, m_start}, 32'h0);
        check("rst_mregs", {m_addr, m_rw, m_data1, m_data2, m_ack3p}, 32'h0);
    endtask

    // One normal transfer: req already driven, state IDLE, m_free=1
    task automatic serve(input vec_t v);
        int bad;
        step();
        check("gnt_at_1", gnt, v.gnt);
        check("start_low_at_1", m_start, 0);
        check("m_fields", {m_addr, m_rw, m_data1, m_data2, m_ack3p},
              {7'h0, v.addr, v.rw, v.d1, v.d2, v.ack});
        step();
        check("start_at_2", m_start, 1);
        step();
        step();
        m_free = 1'b0;
        step();
        check("start_drop", {m_start, gnt}, {1'b0, v.gnt});
        bad = 0;
        repeat (40) begin
            step();
            if (done !== 4'b0 || err !== 4'b0 || m_start !== 1'b0) bad++;
        end
        check("busy_quiet", bad, 0);
        m_free = 1'b1;
        step();
        check("done_pulse", {done, err, gnt}, {v.gnt, 4'b0, v.gnt});
        step();
        check("fin_clear", {done, err, gnt}, 0);
    endtask

    initial begin
        int cnt;
        int n;
        int bad;
        rst    = 1'b1;
        req    = 4'b0;
        m_free = 1'b1;
        req_addr = '0; req_rw = '0; req_data1 = '0; req_data2 = '0; req_ack3p = '0;
        set_fields();

        tbl[0] = '{1'b1, 4'b0010, 4'b0010, 7'h50, 1'b0, 8'hA5, 8'h13, 1'b1};
        tbl[1] = '{1'b0, 4'b1000, 4'b1000, 7'h52, 1'b1, 8'hA7, 8'h33, 1'b1};
        tbl[2] = '{1'b0, 4'b0101, 4'b0001, 7'h4F, 1'b0, 8'hA4, 8'h03, 1'b0};
        tbl[3] = '{1'b1, 4'b1111, 4'b0001, 7'h4F, 1'b0, 8'hA4, 8'h03, 1'b0};
        tbl[4] = '{1'b0, 4'b1111, 4'b0010, 7'h50, 1'b0, 8'hA5, 8'h13, 1'b1};
        tbl[5] = '{1'b0, 4'b1111, 4'b0100, 7'h51, 1'b1, 8'hA6, 8'h23, 1'b0};
        tbl[6] = '{1'b0, 4'b1111, 4'b1000, 7'h52, 1'b1, 8'hA7, 8'h33, 1'b1};
        tbl[7] = '{1'b0, 4'b1111, 4'b0001, 7'h4F, 1'b0, 8'hA4, 8'h03, 1'b0};

        step();
        rst = 1'b0;
        check("reset_state", {gnt, done, err, 3'b0, m_start}, 32'h0);

        // Single requests and round-robin over all four held requests
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].do_rst) do_reset();
            req = tbl[i].req;
            serve(tbl[i]);
        end
        req = 4'b0;

        // Launch timeout: master never goes busy
        do_reset();
        req = 4'b0100;
        step();
        check("lto_gnt", gnt, 4'b0100);
        cnt = 0; n = 0; bad = 0;
        repeat (25) begin
            step();
            if (m_start === 1'b1) cnt++;
            if (done !== 4'b0) bad++;
            if (err !== 4'b0) begin
                n++;
                check("lto_err_owner", {err, gnt}, {4'b0100, 4'b0100});
                req = 4'b0;
            end
        end
        check("lto_start_cycles", cnt, 16);
        check("lto_err_count", n, 1);
        check("lto_no_done", bad, 0);
        check("lto_idle", {gnt, 3'b0, m_start}, 0);

        // Transfer timeout: master goes busy and never returns; rr_ptr now 3
        req = 4'b1010;
        step();
        check("xto_gnt", gnt, 4'b1000);
        step();
        m_free = 1'b0;
        step();
        check("xto_in_xfer", m_start, 0);
        n = 0;
        for (int k = 1; k <= 5000 && n == 0; k++) begin
            step();
            if (err !== 4'b0) n = k;
        end
        check("xto_cycles", n, 4096);
        check("xto_err", {err, done, gnt}, {4'b1000, 4'b0, 4'b1000});
        req = 4'b0010;
        m_free = 1'b1;
        step();
        check("xto_gnt_clear", {gnt, err}, 0);
        step();
        check("xto_next_gnt", gnt, 4'b0010);
        step();
        m_free = 1'b0;
        step();
        m_free = 1'b1;
        step();
        check("xto_next_done", done, 4'b0010);
        req = 4'b0;
        step();

        // Owner edits its fields and drops req mid-transfer; rr_ptr now 2
        req = 4'b0100;
        step();
        check("mid_gnt", gnt, 4'b0100);
        step();
        m_free = 1'b0;
        step();
        req_addr[14 +: 7] = 7'h7F;
        req_data1[16 +: 8] = 8'h00;
        req = 4'b0;
        step();
        step();
        check("mid_hold", {m_addr, m_data1, gnt}, {7'h51, 8'hA6, 4'b0100});
        m_free = 1'b1;
        step();
        check("mid_done", done, 4'b0100);
        step();
        set_fields();

        // Reset while in XFER
        req = 4'b0001;
        step();
        check("rstx_gnt", gnt, 4'b0001);
        step();
        m_free = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0;
        m_free = 1'b1;
        check("rstx_outs", {gnt, done, err, 3'b0, m_start}, 0);
        check("rstx_mregs", {m_addr, m_rw, m_data1, m_data2, m_ack3p}, 0);
        step();
        check("rstx_no_pulse", {gnt, done, err}, 0);

        // Busy master at IDLE blocks the grant
        m_free = 1'b0;
        req = 4'b0001;
        bad = 0;
        repeat (5) begin
            step();
            if (gnt !== 4'b0) bad++;
        end
        check("busy_no_gnt", bad, 0);
        m_free = 1'b1;
        step();
        check("busy_then_gnt", gnt, 4'b0001);
        req = 4'b0;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
